// File: rtl/prism_cfg_loader.sv
// prism_cfg_loader: buffers (addr,data) writes and replays them into PRISM under reset, then releases it.
// Optional `PRISM_LOADER_CHECKSUM_EN adds an XOR checksum check on the written data.
module prism_cfg_loader #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [5:0]  push_addr,
  input  logic [31:0] push_data,
  output logic        push_ready,
  input  logic        commit,
  input  logic        run_after,
  input  logic [31:0] expect_sum,
  input  logic        abort,
  output logic [5:0]  dbg_addr,
  output logic        dbg_wr,
  output logic [31:0] dbg_wdata,
  output logic        prism_reset,
  output logic        prism_enable,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, HALT, LOAD, SETTLE} state_t;
  state_t state, state_n;
  logic [37:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [3:0] level, level_n, cnt, cnt_n;
  logic push_ok, go, pop, flush, bad, run_lat, run_n;
  logic dbg_wr_n, done_n, prst_n, en_n, err_n;
  assign push_ready = state == IDLE && level < 4'(FIFO_DEPTH);
  assign push_ok    = push && push_ready;
  assign go         = state == IDLE && commit && (level != 4'd0 || push_ok);
  assign busy       = state != IDLE;
  assign fifo_level = level;
`ifdef PRISM_LOADER_CHECKSUM_EN
  logic [31:0] acc, sum_lat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      sum_lat <= '0;
    end else begin
      acc <= go ? '0 : pop ? acc ^ mem[rp][31:0] : acc;
      if (go) sum_lat <= expect_sum;
    end
  end
  assign bad = acc != sum_lat;
`else
  logic unused_sum;
  assign unused_sum = ^expect_sum;
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= {push_addr, push_data};
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    run_n    = run_lat;
    pop      = 1'b0;
    flush    = 1'b0;
    done_n   = 1'b0;
    prst_n   = prism_reset;
    en_n     = prism_enable;
    err_n    = error;
    case (state)
      IDLE: begin
        if (go) begin
          state_n = HALT;
          prst_n  = 1'b1;
          en_n    = 1'b0;
          err_n   = 1'b0;
          run_n   = run_after;
        end else done_n = commit;
      end
      HALT: begin
        state_n = LOAD;
        pop     = 1'b1;
      end
      LOAD: begin
        pop = level != 4'd0;
        if (level == 4'd0) begin
          state_n = SETTLE;
          cnt_n   = 4'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd0) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = error | bad;
          prst_n  = bad;
          en_n    = run_lat && !bad;
        end
      end
    endcase
    // abort overrides everything decided above
    if (abort && state != IDLE) begin
      state_n = IDLE;
      pop     = 1'b0;
      flush   = 1'b1;
      done_n  = 1'b0;
      prst_n  = 1'b1;
      en_n    = 1'b0;
      err_n   = 1'b1;
    end
    dbg_wr_n = pop;
    level_n  = flush ? 4'd0 : level + 4'(push_ok) - 4'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wp           <= '0;
      rp           <= '0;
      level        <= '0;
      cnt          <= '0;
      run_lat      <= 1'b0;
      dbg_addr     <= '0;
      dbg_wdata    <= '0;
      dbg_wr       <= 1'b0;
      done         <= 1'b0;
      prism_reset  <= 1'b0;
      prism_enable <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      level        <= level_n;
      cnt          <= cnt_n;
      run_lat      <= run_n;
      wp           <= flush ? '0 : wp + AW'(push_ok);
      rp           <= flush ? '0 : rp + AW'(pop);
      dbg_wr       <= dbg_wr_n;
      done         <= done_n;
      prism_reset  <= prst_n;
      prism_enable <= en_n;
      error        <= err_n;
      if (pop) {dbg_addr, dbg_wdata} <= mem[rp];
    end
  end
endmodule

// File: tb/tb_prism_cfg_loader.sv
// tb_prism_cfg_loader: directed self-checking bench for prism_cfg_loader (FIFO_DEPTH=4, SETTLE_CYCLES=2).
module tb_prism_cfg_loader;
  logic clk = 0, rst = 0, push = 0, commit = 0, run_after = 0, abort = 0;
  logic [5:0] push_addr = 0;
  logic [31:0] push_data = 0, expect_sum = 0;
  logic push_ready, dbg_wr, prism_reset, prism_enable, busy, done, error;
  logic [5:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [3:0] fifo_level;
  int checks = 0, fails = 0;
  logic [5:0] wa [8];
  logic [31:0] wd [8];
  int nwr, done_at;
  logic got_done;

  prism_cfg_loader dut (
    .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .push_data(push_data),
    .push_ready(push_ready), .commit(commit), .run_after(run_after), .expect_sum(expect_sum),
    .abort(abort), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr), .dbg_wdata(dbg_wdata),
    .prism_reset(prism_reset), .prism_enable(prism_enable), .busy(busy), .done(done),
    .error(error), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [5:0] a, input logic [31:0] d);
    push = 1; push_addr = a; push_data = d;
    tick();
    push = 0;
  endtask

  task automatic run_seq(input logic ra, input logic [31:0] es);
    commit = 1; run_after = ra; expect_sum = es;
    nwr = 0; got_done = 0; done_at = 0;
    tick();
    commit = 0; push = 0;
    for (int c = 1; c <= 30; c++) begin
      if (dbg_wr && nwr < 8) begin wa[nwr] = dbg_addr; wd[nwr] = dbg_wdata; nwr++; end
      if (done) begin got_done = 1; done_at = c; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++; if ({dbg_wr, dbg_addr, dbg_wdata} !== 39'h0) begin fails++; $display("FAIL reset_dbg: got %0h required 0", {dbg_wr, dbg_addr, dbg_wdata}); end
    checks++; if ({prism_reset, prism_enable, done, error, busy} !== 5'b0) begin fails++; $display("FAIL reset_ctl: got %b required 00000", {prism_reset, prism_enable, done, error, busy}); end
    checks++; if (fifo_level !== 4'd0 || push_ready !== 1'b1) begin fails++; $display("FAIL reset_fifo: level %0d ready %b required 0 1", fifo_level, push_ready); end
    rst = 0;
    tick();
  endtask

  task automatic test_load();
    logic [5:0] ea [3];
    logic [31:0] ed [3];
    ea = '{6'h04, 6'h08, 6'h0C};
    ed = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) push_one(ea[i], ed[i]);
    checks++; if (fifo_level !== 4'd3) begin fails++; $display("FAIL load_level: got %0d required 3", fifo_level); end
    commit = 1; run_after = 1; expect_sum = 32'h0;
    tick();
    commit = 0;
    for (int c = 1; c <= 8; c++) begin
      checks++; if (dbg_wr !== (c >= 2 && c <= 4)) begin fails++; $display("FAIL load_wr c%0d: got %b required %b", c, dbg_wr, c >= 2 && c <= 4); end
      checks++; if (done !== (c == 7)) begin fails++; $display("FAIL load_done c%0d: got %b required %b", c, done, c == 7); end
      checks++; if (busy !== (c <= 6)) begin fails++; $display("FAIL load_busy c%0d: got %b required %b", c, busy, c <= 6); end
      if (c >= 2 && c <= 4) begin
        checks++; if (dbg_addr !== ea[c-2] || dbg_wdata !== ed[c-2]) begin fails++; $display("FAIL load_data c%0d: got %0h/%0h required %0h/%0h", c, dbg_addr, dbg_wdata, ea[c-2], ed[c-2]); end
      end
      if (c == 1) begin
        checks++; if (prism_reset !== 1'b1 || prism_enable !== 1'b0) begin fails++; $display("FAIL load_halt: rst %b en %b required 1 0", prism_reset, prism_enable); end
      end
      if (c == 7) begin
        checks++; if (prism_reset !== 1'b0 || prism_enable !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL load_release: rst %b en %b err %b required 0 1 0", prism_reset, prism_enable, error); end
      end
      tick();
    end
  endtask

  task automatic test_empty(input logic exp_en, input logic exp_rst, input logic exp_err);
    run_seq(1'b1, 32'h5A5A);
    checks++; if (!got_done || done_at !== 1) begin fails++; $display("FAIL empty_done: got %b at %0d required 1 at 1", got_done, done_at); end
    checks++; if (nwr !== 0 || busy !== 1'b0) begin fails++; $display("FAIL empty_wr: writes %0d busy %b required 0 0", nwr, busy); end
    checks++; if ({prism_enable, prism_reset, error} !== {exp_en, exp_rst, exp_err}) begin fails++; $display("FAIL empty_ctl: got %b required %b", {prism_enable, prism_reset, error}, {exp_en, exp_rst, exp_err}); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      push = 1; push_addr = 6'(i); push_data = 32'h40 + i;
      checks++; if (push_ready !== (i < 4)) begin fails++; $display("FAIL full_ready p%0d: got %b required %b", i, push_ready, i < 4); end
      tick();
    end
    push = 0;
    checks++; if (fifo_level !== 4'd4) begin fails++; $display("FAIL full_level: got %0d required 4", fifo_level); end
    run_seq(1'b0, 32'h0);
    checks++; if (nwr !== 4 || !got_done) begin fails++; $display("FAIL full_writes: got %0d done %b required 4 1", nwr, got_done); end
    checks++; if (wd[0] !== 32'h40 || wd[3] !== 32'h43 || wa[3] !== 6'd3) begin fails++; $display("FAIL full_order: got %0h %0h %0h required 40 43 3", wd[0], wd[3], wa[3]); end
    checks++; if (prism_enable !== 1'b0 || error !== 1'b0 || prism_reset !== 1'b0) begin fails++; $display("FAIL full_end: en %b err %b rst %b required 0 0 0", prism_enable, error, prism_reset); end
    tick();
  endtask

  task automatic test_abort();
    int wr = 0, dn = 0;
    for (int i = 0; i < 3; i++) push_one(6'h10 + 6'(i), 32'hA0 + i);
    commit = 1; run_after = 1;
    tick();
    commit = 0;
    tick();
    checks++; if (dbg_wr !== 1'b1 || dbg_addr !== 6'h10) begin fails++; $display("FAIL abort_first: wr %b addr %0h required 1 10", dbg_wr, dbg_addr); end
    wr += int'(dbg_wr);
    abort = 1;
    tick();
    abort = 0;
    checks++; if (busy !== 1'b0 || fifo_level !== 4'd0 || dbg_wr !== 1'b0) begin fails++; $display("FAIL abort_state: busy %b level %0d wr %b required 0 0 0", busy, fifo_level, dbg_wr); end
    checks++; if ({error, prism_reset, prism_enable, done} !== 4'b1100) begin fails++; $display("FAIL abort_ctl: got %b required 1100", {error, prism_reset, prism_enable, done}); end
    for (int c = 0; c < 5; c++) begin
      wr += int'(dbg_wr); dn += int'(done);
      tick();
    end
    checks++; if (wr !== 1 || dn !== 0) begin fails++; $display("FAIL abort_count: writes %0d dones %0d required 1 0", wr, dn); end
  endtask

  task automatic test_reset_mid();
    int wr = 0;
    push_one(6'h21, 32'h1); push_one(6'h22, 32'h2);
    commit = 1; run_after = 1;
    tick();
    commit = 0;
    tick();
    rst = 1;
    #1;
    checks++; if (dbg_wr !== 1'b0 || busy !== 1'b0 || fifo_level !== 4'd0 || prism_reset !== 1'b0) begin fails++; $display("FAIL rstmid_state: wr %b busy %b level %0d prst %b required 0 0 0 0", dbg_wr, busy, fifo_level, prism_reset); end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      wr += int'(dbg_wr);
      tick();
    end
    checks++; if (wr !== 0) begin fails++; $display("FAIL rstmid_writes: got %0d required 0", wr); end
  endtask

  task automatic test_checksum();
`ifdef PRISM_LOADER_CHECKSUM_EN
    push_one(6'h01, 32'h0F);
    push = 1; push_addr = 6'h02; push_data = 32'hF0;
    run_seq(1'b1, 32'hFF);
    checks++; if (nwr !== 2 || !got_done) begin fails++; $display("FAIL sum_ok_writes: got %0d done %b required 2 1", nwr, got_done); end
    checks++; if (error !== 1'b0 || prism_enable !== 1'b1) begin fails++; $display("FAIL sum_ok: err %b en %b required 0 1", error, prism_enable); end
    tick();
    push_one(6'h01, 32'h0F); push_one(6'h02, 32'hF0);
    run_seq(1'b1, 32'h00);
    checks++; if (!got_done) begin fails++; $display("FAIL sum_bad_done: got 0 required 1"); end
    checks++; if ({error, prism_enable, prism_reset} !== 3'b101) begin fails++; $display("FAIL sum_bad: got %b required 101", {error, prism_enable, prism_reset}); end
`else
    push_one(6'h01, 32'h0F);
    run_seq(1'b1, 32'h1234);
    checks++; if (!got_done || nwr !== 1) begin fails++; $display("FAIL nosum_done: done %b writes %0d required 1 1", got_done, nwr); end
    checks++; if ({error, prism_enable, prism_reset} !== 3'b010) begin fails++; $display("FAIL nosum_ctl: got %b required 010", {error, prism_enable, prism_reset}); end
`endif
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load();
    test_empty(1'b1, 1'b0, 1'b0);
    test_full();
    test_abort();
    test_empty(1'b0, 1'b1, 1'b1);
    test_reset_mid();
    test_checksum();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/prism_cfg_loader.md
PRISM_CFG_LOADER -- requirements
Module: prism_cfg_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of (addr,data) entries buffered (power of two, 2..8).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles between last write and release (1..15).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- push  in  1  enqueue request.
- push_addr  in  6  PRISM debug address.
- push_data  in  32  PRISM debug write data.
- push_ready  out  1  entry accepted this cycle if push high.
- commit  in  1  start load sequence.
- run_after  in  1  sampled on commit; enable PRISM after load.
- expect_sum  in  32  sampled on commit; expected checksum.
- abort  in  1  cancel sequence.
- dbg_addr  out  6  to PRISM debug_addr.
- dbg_wr  out  1  to PRISM debug_wr.
- dbg_wdata  out  32  to PRISM debug_wdata.
- prism_reset  out  1  to PRISM debug_reset.
- prism_enable  out  1  to PRISM fsm_enable.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky abort/checksum flag.
- fifo_level  out  4  entries held.

Function
REQ-004 SHALL implement states IDLE, HALT, LOAD, SETTLE; all outputs registered except push_ready, busy, fifo_level.
REQ-005 SHALL assert push_ready iff state==IDLE and fifo_level<FIFO_DEPTH; push while not ready dropped, no side effect.
REQ-006 SHALL, in IDLE, on commit with fifo_level>0 (counting a same-cycle accepted push): latch run_after/expect_sum, clear error, enter HALT.
REQ-007 SHALL, on commit with empty FIFO in IDLE: pulse done next cycle, no state, prism_reset, prism_enable, or error change.
REQ-008 SHALL ignore commit outside IDLE.
REQ-009 SHALL drive prism_reset=1, prism_enable=0 from first HALT cycle (commit edge N -> visible N+1); HALT lasts exactly one cycle.
REQ-010 SHALL, in LOAD, pop one entry per cycle in FIFO order, presenting addr/data with dbg_wr=1; first write visible N+2; writes on consecutive cycles, count equals level at commit.
REQ-011 SHALL enter SETTLE after the last pop; dbg_wr=0 for SETTLE_CYCLES cycles.
REQ-012 SHALL, at SETTLE end: prism_reset=0, prism_enable=run_after latched, done=1 for one cycle, return to IDLE.
REQ-013 SHALL keep dbg_wr=0 in all states except LOAD; dbg_addr/dbg_wdata hold last value otherwise.
REQ-014 SHALL, on abort in HALT/LOAD/SETTLE: next cycle IDLE, flush FIFO, dbg_wr=0, prism_reset=1, prism_enable=0, error=1, no done; abort in IDLE ignored.
REQ-015 SHALL give abort priority over every other same-cycle event.
REQ-016 SHALL wrap FIFO pointers modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH.

Reset
REQ-017 SHALL, while rst high: IDLE, FIFO empty, dbg_wr=0, dbg_addr=0, dbg_wdata=0, prism_reset=0, prism_enable=0, done=0, error=0, checksum=0.
REQ-018 SHALL, on rst mid-sequence, abandon it immediately with no further dbg_wr.

Configuration
REQ-019 SHALL, with PRISM_LOADER_CHECKSUM_EN defined: XOR-accumulate every dbg_wdata written in LOAD (cleared on commit); at SETTLE end, on mismatch with expect_sum, set error=1, hold prism_reset=1, prism_enable=0, still pulse done.
REQ-020 SHALL, without PRISM_LOADER_CHECKSUM_EN: no accumulator, expect_sum ignored, error set only by abort.

Verification
REQ-021 SHALL cover: push 3 entries (0x04/0x11,0x08/0x22,0x0C/0x33), commit run_after=1 at N -> prism_reset N+1, dbg_wr N+2..N+4 in order, done+enable=1 at N+7.
REQ-022 SHALL cover: 5 pushes with FIFO_DEPTH=4 -> push_ready low after 4th, 5th dropped, fifo_level=4.
REQ-023 SHALL cover: abort during 2nd LOAD write -> exactly 1 write, fifo_level=0, error=1, prism_reset=1, no done.
REQ-024 SHALL cover: commit with empty FIFO -> done pulse, no dbg_wr, prism_enable unchanged.
REQ-025 SHALL cover (macro on): data 0x0F,0xF0, expect_sum=0xFF -> error=0, enable=1; expect_sum=0x00 -> error=1, enable=0, done pulses.
